// File: rtl/priority_encoder_scan_display.sv
// priority_encoder_scan_display: MSB-priority encoder with hold/peak modes shown on a scanned hex 7-seg display
//  clk, rst (async, active-high); data[DATA_W]; sticky (peak-hold); hold (freeze); clear (reload pulse)
//  code[IDX_W] / code_valid: registered index of highest set bit and whether any bit was set
//  seg[7] gfedcba, dp (lit = no data), dig_sel[DIGITS] one-hot; all registered, active-high
module priority_encoder_scan_display #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 2,
  parameter int SCAN_DIV = 1000,
  parameter int LZB = 1,
  localparam int IDX_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              sticky,
  input  logic              hold,
  input  logic              clear,
  output logic [IDX_W-1:0]  code,
  output logic              code_valid,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] dig_sel
);
  localparam int NW = DIGITS * 4;
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int SW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [IDX_W-1:0] idx, code_d, code_q;
  logic any, load, wrap, valid_d, valid_q, dp_d, dp_q;
  logic [PW-1:0] pre_d, pre_q;
  logic [SW-1:0] ptr_d, ptr_q;
  logic [NW-1:0] sh;
  logic [6:0] seg_d, seg_q;
  logic [DIGITS-1:0] sel_d, sel_q;
  always_comb begin
    idx = '0;
    for (int i = 0; i < DATA_W; i++)
      if (data[i]) idx = IDX_W'(i);
  end
  assign any = |data;
  // clear reloads unconditionally; in peak-hold only a strictly higher valid index replaces the code
  assign load = clear || (!hold && (!sticky || (any && (!valid_q || idx > code_q))));
  assign code_d = load ? idx : code_q;
  assign valid_d = load ? any : valid_q;
  assign wrap = pre_q == PW'(SCAN_DIV - 1);
  assign pre_d = wrap ? '0 : pre_q + 1'b1;
  assign ptr_d = !wrap ? ptr_q : ptr_q == SW'(DIGITS - 1) ? '0 : ptr_q + 1'b1;
  // sh holds the current nibble and every more significant one, so sh==0 means a leading zero
  assign sh = NW'(code_q) >> (4 * ptr_q);
  assign seg_d = (!valid_q || (LZB != 0 && ptr_q != '0 && sh == '0)) ? '0 : HEX[sh[3:0]];
  assign dp_d = !valid_q && ptr_q == '0;
  assign sel_d = DIGITS'(1) << ptr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      code_q <= '0;
      valid_q <= 1'b0;
      pre_q <= '0;
      ptr_q <= '0;
      seg_q <= '0;
      dp_q <= 1'b0;
      sel_q <= '0;
    end else begin
      code_q <= code_d;
      valid_q <= valid_d;
      pre_q <= pre_d;
      ptr_q <= ptr_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      sel_q <= sel_d;
    end
  assign code = code_q;
  assign code_valid = valid_q;
  assign seg = seg_q;
  assign dp = dp_q;
  assign dig_sel = sel_q;
endmodule

// File: tb/tb_priority_encoder_scan_display.sv
// tb_priority_encoder_scan_display: directed vector and scan checks of the encoder/display
module tb_priority_encoder_scan_display;
  logic clk = 0, rst = 1, sticky = 0, hold = 0, clear = 0;
  logic [15:0] data = 0;
  logic [255:0] wdata = 0;
  logic [3:0] code_a, code_b;
  logic [7:0] code_w;
  logic val_a, val_b, val_w, dp_a, dp_b, dp_w;
  logic [6:0] seg_a, seg_b, seg_w;
  logic [1:0] sel_a, sel_b, sel_w;
  int checks = 0, errors = 0, n = 0;
  always #5 clk = ~clk;
  priority_encoder_scan_display #(.DATA_W(16), .DIGITS(2), .SCAN_DIV(4), .LZB(1)) dut_a (
    .clk(clk), .rst(rst), .data(data), .sticky(sticky), .hold(hold), .clear(clear),
    .code(code_a), .code_valid(val_a), .seg(seg_a), .dp(dp_a), .dig_sel(sel_a));
  priority_encoder_scan_display #(.DATA_W(16), .DIGITS(2), .SCAN_DIV(4), .LZB(0)) dut_b (
    .clk(clk), .rst(rst), .data(data), .sticky(sticky), .hold(hold), .clear(clear),
    .code(code_b), .code_valid(val_b), .seg(seg_b), .dp(dp_b), .dig_sel(sel_b));
  priority_encoder_scan_display #(.DATA_W(256), .DIGITS(2), .SCAN_DIV(4), .LZB(1)) dut_w (
    .clk(clk), .rst(rst), .data(wdata), .sticky(sticky), .hold(hold), .clear(clear),
    .code(code_w), .code_valid(val_w), .seg(seg_w), .dp(dp_w), .dig_sel(sel_w));
  typedef struct {
    logic [15:0] d;
    logic st, hd, cl;
    int code;
    logic valid;
  } vec_t;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    n++;
  endtask
  function automatic int slot_of(input int e);
    return ((e - 1) / 4) % 2;
  endfunction
  initial begin
    vec_t v[$];
    v.push_back('{16'h0000, 0, 0, 0, 0, 0});
    v.push_back('{16'h8001, 0, 0, 0, 15, 1});
    v.push_back('{16'h0010, 1, 0, 1, 4, 1});
    v.push_back('{16'h0004, 1, 0, 0, 4, 1});
    v.push_back('{16'h0000, 1, 0, 0, 4, 1});
    v.push_back('{16'h0110, 1, 0, 0, 8, 1});
    v.push_back('{16'h0100, 1, 0, 0, 8, 1});
    v.push_back('{16'h0002, 1, 0, 1, 1, 1});
    v.push_back('{16'h0000, 0, 0, 0, 0, 0});
    v.push_back('{16'h0001, 0, 1, 0, 0, 0});
    v.push_back('{16'h4000, 0, 1, 0, 0, 0});
    v.push_back('{16'h4000, 0, 0, 0, 14, 1});
    v.push_back('{16'h0002, 0, 1, 1, 1, 1});
    v.push_back('{16'h0003, 0, 0, 0, 1, 1});
    v.push_back('{16'hFFFF, 0, 0, 0, 15, 1});
    v.push_back('{16'h0000, 0, 0, 0, 0, 0});
    #12;
    chk("reset code", code_a, 0);
    chk("reset valid", val_a, 0);
    chk("reset seg", seg_a, 0);
    chk("reset dp", dp_a, 0);
    chk("reset dig_sel", sel_a, 0);
    rst = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      chk($sformatf("scan dig_sel e%0d", n), sel_a, slot_of(n) ? 2 : 1);
      chk($sformatf("blank dp e%0d", n), dp_a, slot_of(n) ? 0 : 1);
      chk($sformatf("blank seg e%0d", n), seg_a, 0);
    end
    data = 16'h8001;
    tick();
    chk("8001 code", code_a, 15);
    chk("8001 valid", val_a, 1);
    tick();
    for (int e = 0; e < 8; e++) begin
      tick();
      chk($sformatf("8001 seg e%0d", n), seg_a, slot_of(n) ? 7'h00 : 7'h71);
      chk($sformatf("8001 lzb0 seg e%0d", n), seg_b, slot_of(n) ? 7'h3F : 7'h71);
      chk($sformatf("8001 dp e%0d", n), dp_a, 0);
    end
    foreach (v[i]) begin
      data = v[i].d;
      sticky = v[i].st;
      hold = v[i].hd;
      clear = v[i].cl;
      tick();
      chk($sformatf("vec%0d code", i), code_a, v[i].code);
      chk($sformatf("vec%0d valid", i), val_a, v[i].valid);
    end
    {sticky, hold, clear} = 3'b000;
    wdata = '0;
    wdata[255] = 1'b1;
    tick();
    chk("wide code FF", code_w, 8'hFF);
    tick();
    for (int e = 0; e < 8; e++) begin
      tick();
      chk($sformatf("wide FF seg e%0d", n), seg_w, 7'h71);
    end
    wdata = 256'd1;
    tick();
    chk("wide code 0", code_w, 0);
    chk("wide valid", val_w, 1);
    tick();
    for (int e = 0; e < 8; e++) begin
      tick();
      chk($sformatf("wide 0 seg e%0d", n), seg_w, slot_of(n) ? 7'h00 : 7'h3F);
    end
    data = 16'h8001;
    tick();
    tick();
    #1;
    rst = 1;
    #1;
    chk("async code", code_a, 0);
    chk("async valid", val_a, 0);
    chk("async seg", seg_a, 0);
    chk("async dp", dp_a, 0);
    chk("async dig_sel", sel_a, 0);
    @(negedge clk);
    rst = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
